// File: rtl/seg_stream_decoder.sv
// Snooper for a chained seven-segment shift-register display bus: recovers NDIG hex digits
// from the active-low segment bytes each time the frame latch rises.
module seg_stream_decoder #(
    parameter int NDIG        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_in,
    input  logic              sdata_in,
    input  logic              latch_in,
    output logic [4*NDIG-1:0] hex_out,
    output logic [NDIG-1:0]   dp_out,
    output logic [NDIG-1:0]   blank_out,
    output logic [NDIG-1:0]   err_out,
    output logic              len_err,
    output logic              frame_valid,
    output logic [15:0]       frame_cnt
);

    localparam int NBITS = 8 * NDIG;
    localparam int CW    = $clog2(NBITS + 2);
    localparam logic [CW-1:0] BIT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] BIT_MAX  = CW'(NBITS + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   latch_dly_q, latch_dly_d;

    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic [4*NDIG-1:0] hex_q, hex_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              len_err_q, len_err_d;
    logic              frame_valid_q, frame_valid_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              sclk_rise;
    logic              latch_rise;
    logic              sdata_s;
    logic [5:0]        dec;

    // Returns {err, blank, hex} for the seven active-low segment bits {g,f,e,d,c,b,a}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b00_0000;
        case (seg)
            7'h40: r[3:0] = 4'h0;
            7'h79: r[3:0] = 4'h1;
            7'h24: r[3:0] = 4'h2;
            7'h30: r[3:0] = 4'h3;
            7'h19: r[3:0] = 4'h4;
            7'h12: r[3:0] = 4'h5;
            7'h02: r[3:0] = 4'h6;
            7'h78: r[3:0] = 4'h7;
            7'h00: r[3:0] = 4'h8;
            7'h18: r[3:0] = 4'h9;
            7'h08: r[3:0] = 4'hA;
            7'h03: r[3:0] = 4'hB;
            7'h27: r[3:0] = 4'hC;
            7'h21: r[3:0] = 4'hD;
            7'h06: r[3:0] = 4'hE;
            7'h0E: r[3:0] = 4'hF;
            7'h7F: r[4]   = 1'b1;
            default: r[5] = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
        sclk_dly_d   = sclk_sync_q[SYNC_STAGES-1];
        latch_dly_d  = latch_sync_q[SYNC_STAGES-1];
        sclk_rise    = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
        latch_rise   = latch_sync_q[SYNC_STAGES-1] & ~latch_dly_q;
        sdata_s      = sdata_sync_q[SYNC_STAGES-1];
    end

    // A shift and a latch in the same cycle: the capture sees the freshly shifted bit.
    always_comb begin
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        hex_d         = hex_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        err_d         = err_q;
        len_err_d     = len_err_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        dec           = 6'b00_0000;

        if (sclk_rise) begin
            shreg_d = {shreg_q[NBITS-2:0], sdata_s};
            if (bitcnt_q != BIT_MAX) begin
                bitcnt_d = bitcnt_q + CW'(1);
            end
        end

        if (latch_rise) begin
            for (int i = 0; i < NDIG; i++) begin
                dec            = decode_seg(shreg_d[8*i +: 7]);
                hex_d[4*i +: 4] = dec[3:0];
                blank_d[i]     = dec[4];
                err_d[i]       = dec[5];
                dp_d[i]        = ~shreg_d[8*i+7];
            end
            len_err_d     = (bitcnt_d != BIT_FULL);
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            bitcnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q   <= '0;
            sdata_sync_q  <= '0;
            latch_sync_q  <= '0;
            sclk_dly_q    <= 1'b0;
            latch_dly_q   <= 1'b0;
            shreg_q       <= '1;
            bitcnt_q      <= '0;
            hex_q         <= '0;
            dp_q          <= '0;
            blank_q       <= '1;
            err_q         <= '0;
            len_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            sdata_sync_q  <= sdata_sync_d;
            latch_sync_q  <= latch_sync_d;
            sclk_dly_q    <= sclk_dly_d;
            latch_dly_q   <= latch_dly_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            hex_q         <= hex_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
            len_err_q     <= len_err_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hex_out     = hex_q;
    assign dp_out      = dp_q;
    assign blank_out   = blank_q;
    assign err_out     = err_q;
    assign len_err     = len_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_seg_stream_decoder.sv
// Bench for seg_stream_decoder: a bit-queue model of the display bus predicts every output
// each cycle, with literal frames pinning the glyph table, length errors and counter wrap.
module tb_seg_stream_decoder;

    localparam int NDIG  = 4;
    localparam int SYNC  = 2;
    localparam int NBITS = 8 * NDIG;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk_in;
    logic        sdata_in;
    logic        latch_in;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  blank_out;
    logic [3:0]  err_out;
    logic        len_err;
    logic        frame_valid;
    logic [15:0] frame_cnt;

    seg_stream_decoder #(.NDIG(NDIG), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_in     (sclk_in),
        .sdata_in    (sdata_in),
        .latch_in    (latch_in),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .blank_out   (blank_out),
        .err_out     (err_out),
        .len_err     (len_err),
        .frame_valid (frame_valid),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Model state: every bit seen on the bus (front-filled with the all-ones reset image).
    bit          mbits [$];
    int          mcnt;
    logic [15:0] exp_hex, pend_hex;
    logic [3:0]  exp_dp, pend_dp, exp_blank, pend_blank, exp_err, pend_err;
    logic        exp_len, pend_len, exp_fv;
    logic [15:0] exp_cnt;
    int          lat_cd = 0;
    bit          started = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_decode(input logic [7:0] b, output logic [3:0] h,
                                         output logic dp, output logic blank, output logic err);
        dp    = ~b[7];
        h     = 4'h0;
        blank = 1'b0;
        err   = 1'b1;
        if (b[6:0] == 7'h7F) begin
            blank = 1'b1;
            err   = 1'b0;
        end else begin
            for (int g = 0; g < 16; g++) begin
                if (glyph[g] == b[6:0]) begin
                    h   = 4'(g);
                    err = 1'b0;
                end
            end
        end
    endfunction

    task automatic model_reset();
        mbits.delete();
        for (int k = 0; k < NBITS; k++) mbits.push_back(1'b1);
        mcnt      = 0;
        exp_hex   = 16'h0000;
        exp_dp    = 4'h0;
        exp_blank = 4'hF;
        exp_err   = 4'h0;
        exp_len   = 1'b0;
        exp_cnt   = 16'h0000;
        lat_cd    = 0;
    endtask

    task automatic model_shift(input logic b);
        mbits.push_back(b);
        if (mbits.size() > 2 * NBITS) void'(mbits.pop_front());
        mcnt++;
    endtask

    // Digit i holds the i-th most recent byte on the bus, most significant bit first.
    task automatic model_latch();
        logic [7:0] byt;
        logic [3:0] h;
        logic       dp, bl, er;
        int         base;
        for (int i = 0; i < NDIG; i++) begin
            base = mbits.size() - 8 * (i + 1);
            byt  = 8'h00;
            for (int k = 0; k < 8; k++) byt = {byt[6:0], mbits[base + k]};
            model_decode(byt, h, dp, bl, er);
            pend_hex[4*i +: 4] = h;
            pend_dp[i]         = dp;
            pend_blank[i]      = bl;
            pend_err[i]        = er;
        end
        pend_len = (mcnt != NBITS);
        mcnt     = 0;
        lat_cd   = SYNC + 2;
    endtask

    always @(negedge clk) begin
        if (started) begin
            exp_fv = 1'b0;
            if (lat_cd > 0) begin
                lat_cd--;
                if (lat_cd == 0) begin
                    exp_hex   = pend_hex;
                    exp_dp    = pend_dp;
                    exp_blank = pend_blank;
                    exp_err   = pend_err;
                    exp_len   = pend_len;
                    exp_cnt   = exp_cnt + 16'd1;
                    exp_fv    = 1'b1;
                end
            end
            checkOutput("frame_valid", 16'(frame_valid), 16'(exp_fv));
            checkOutput("hex_out", hex_out, exp_hex);
            checkOutput("dp_out", 16'(dp_out), 16'(exp_dp));
            checkOutput("blank_out", 16'(blank_out), 16'(exp_blank));
            checkOutput("err_out", 16'(err_out), 16'(exp_err));
            checkOutput("len_err", 16'(len_err), 16'(exp_len));
            checkOutput("frame_cnt", frame_cnt, exp_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_latch();
        latch_in = 1'b1;
        model_latch();
        tick(4);
        latch_in = 1'b0;
        tick(4);
    endtask

    task automatic send_bit(input logic b, input bit with_latch);
        sdata_in = b;
        tick(2);
        sclk_in = 1'b1;
        model_shift(b);
        if (with_latch) begin
            latch_in = 1'b1;
            model_latch();
        end
        tick(4);
        sclk_in  = 1'b0;
        latch_in = 1'b0;
        tick(4);
    endtask

    // Sends bits[nbits-1:0] MSB first, then latches (or latches on the last sclk rise).
    task automatic applyStimulus(input logic [63:0] bits, input int nbits, input bit simul);
        for (int k = nbits - 1; k >= 0; k--) send_bit(bits[k], simul && (k == 0));
        if (!simul) do_latch();
    endtask

    task automatic check_frame(input string tag, input logic [15:0] h, input logic [3:0] dp,
                               input logic [3:0] bl, input logic [3:0] er, input logic le,
                               input logic [15:0] cnt);
        checkOutput({tag, "_hex"}, hex_out, h);
        checkOutput({tag, "_dp"}, 16'(dp_out), 16'(dp));
        checkOutput({tag, "_blank"}, 16'(blank_out), 16'(bl));
        checkOutput({tag, "_err"}, 16'(err_out), 16'(er));
        checkOutput({tag, "_len"}, 16'(len_err), 16'(le));
        checkOutput({tag, "_cnt"}, frame_cnt, cnt);
    endtask

    initial begin
        int         n_gl, n_bl, n_er, nb;
        logic [63:0] v;
        logic [7:0]  byt;
        rst_n    = 1'b0;
        sclk_in  = 1'b0;
        sdata_in = 1'b0;
        latch_in = 1'b0;
        model_reset();
        started = 1;
        tick(3);
        check_frame("reset", 16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick(2);

        applyStimulus(64'hC0F9A4B0, 32, 0);
        check_frame("t1", 16'h0123, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1);
        applyStimulus(64'h8883A78E, 32, 0);
        check_frame("t2a", 16'hABCF, 4'h0, 4'h0, 4'h0, 1'b0, 16'd2);
        applyStimulus(64'hA186C0F9, 32, 0);
        check_frame("t2b", 16'hDE01, 4'h0, 4'h0, 4'h0, 1'b0, 16'd3);
        applyStimulus(64'h40FFF67F, 32, 0);
        check_frame("t2c", 16'h0000, 4'b1001, 4'b0101, 4'b0010, 1'b0, 16'd4);

        applyStimulus(64'hC0F9A4, 24, 0);
        check_frame("t3short", 16'h0012, 4'b1000, 4'b1000, 4'b0000, 1'b1, 16'd5);
        applyStimulus(64'h99_C0F9A4B0, 40, 0);
        check_frame("t3long", 16'h0123, 4'h0, 4'h0, 4'h0, 1'b1, 16'd6);

        applyStimulus(64'hB09282F8, 32, 1);
        check_frame("t4simul", 16'h3567, 4'h0, 4'h0, 4'h0, 1'b0, 16'd7);

        for (int k = 0; k < 12; k++) send_bit(1'($urandom_range(0, 1)), 0);
        rst_n = 1'b0;
        model_reset();
        tick(2);
        check_frame("t5reset", 16'h0000, 4'h0, 4'hF, 4'h0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick(2);
        applyStimulus(64'h8098C0F9, 32, 0);
        check_frame("t5after", 16'h8901, 4'h0, 4'h0, 4'h0, 1'b0, 16'd1);

        force dut.frame_cnt_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        tick(2);
        release dut.frame_cnt_q;
        tick(2);
        applyStimulus(64'hC0F9A4B0, 32, 0);
        check_frame("t6wrap", 16'h0123, 4'h0, 4'h0, 4'h0, 1'b0, 16'd0);

        n_gl = 0;
        n_bl = 0;
        n_er = 0;
        for (int f = 0; f < 32; f++) begin
            v = 64'h0;
            for (int j = 0; j < 4; j++) begin
                byt = {1'($urandom_range(0, 1)), 7'(f * 4 + j)};
                v   = {v[55:0], byt};
            end
            applyStimulus(v, 32, 0);
            checkOutput("sweep_onehot", 16'(blank_out & err_out), 16'h0000);
            n_bl += $countones(blank_out);
            n_er += $countones(err_out);
            n_gl += 4 - $countones(blank_out) - $countones(err_out);
        end
        checkOutput("sweep_glyphs", 16'(n_gl), 16'd16);
        checkOutput("sweep_blanks", 16'(n_bl), 16'd1);
        checkOutput("sweep_errs", 16'(n_er), 16'd111);

        for (int f = 0; f < 40; f++) begin
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 44) : NBITS;
            if ($urandom_range(0, 1) == 1) begin
                v = {$urandom(), $urandom()};
            end else begin
                v = 64'h0;
                for (int j = 0; j < 6; j++) begin
                    byt = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
                    v   = {v[55:0], byt};
                end
            end
            applyStimulus(v, nb, ($urandom_range(0, 3) == 0));
        end

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
